// File: rtl/servo_pkg.sv
// Shared definitions for the servo ADC / I-PD control loop: FSM states, ADC frame length
// and the accumulator width helper.
package servo_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StCalcI,
        StCalcP,
        StCalcD,
        StUpdate
    } state_e;

    localparam int unsigned FrameLen = 16;

    // Headroom for u[k-1] plus three W x (W+1) products of either sign.
    function automatic int unsigned acc_width(input int unsigned w);
        return 2 * w + 4;
    endfunction

endpackage

// File: rtl/servo_adc_serial.sv
// Serial ADC frame capture: drives cs/sclk for one 16-clock frame and shifts in sdata
// on each sclk rise. done_o and data_o are valid on the clock of the final rise.
module servo_adc_serial
    import servo_pkg::*;
#(
    parameter int unsigned AdcBits = 12,
    parameter int unsigned SclkDiv = 4
) (
    input  logic               clk_i,
    input  logic               clr_i,
    input  logic               start_i,
    input  logic               sdata_i,
    output logic               cs_o,
    output logic               sclk_o,
    output logic               done_o,
    output logic [AdcBits-1:0] data_o
);
    localparam int unsigned DivW = (SclkDiv > 1) ? $clog2(SclkDiv) : 1;
    localparam int unsigned BitW = $clog2(FrameLen);

    logic               cs_q;
    logic               sclk_q;
    logic [DivW-1:0]    div_q;
    logic [BitW-1:0]    bit_q;
    logic [AdcBits-2:0] shreg_q;
    logic [AdcBits-1:0] frame;
    logic               tick;
    logic               rise;

    // Only the last AdcBits samples survive the shift; the leading pad bits fall off the top.
    assign frame  = {shreg_q, sdata_i};
    assign tick   = !cs_q && (div_q == DivW'(SclkDiv - 1));
    assign rise   = tick && !sclk_q;
    assign done_o = rise && (bit_q == BitW'(FrameLen - 1));
    assign data_o = frame;
    assign cs_o   = cs_q;
    assign sclk_o = sclk_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else if (cs_q) begin
            if (start_i) begin
                cs_q  <= 1'b0;
                div_q <= '0;
                bit_q <= '0;
            end
        end else if (tick) begin
            div_q  <= '0;
            sclk_q <= !sclk_q;
            if (rise) begin
                shreg_q <= frame[AdcBits-2:0];
                bit_q   <= bit_q + 1'b1;
            end
            if (done_o) begin
                cs_q <= 1'b1;
            end
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/servo_adc_ipd_loop.sv
// I-PD servo loop: samples a serial ADC every SAMPLE_DIV clocks, then runs the velocity-form
// controller on one shared multiplier and publishes a rounded, saturated output.
module servo_adc_ipd_loop
    import servo_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned ADC_BITS   = 12,
    parameter int unsigned SCLK_DIV   = 4,
    parameter int unsigned SAMPLE_DIV = 1000
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                Run,
    input  logic                sdata,
    input  logic signed [W-1:0] Ref,
    input  logic signed [W-1:0] Ki,
    input  logic signed [W-1:0] Kp,
    input  logic signed [W-1:0] Kd,
    output logic                cs,
    output logic                sclk,
    output logic signed [W-1:0] Pot,
    output logic signed [W-1:0] Yk,
    output logic                Yk_valid
);
    localparam int unsigned AW = acc_width(W);
    localparam int unsigned CW = $clog2(SAMPLE_DIV);
    localparam int unsigned PW = 2 * W + 1;

    localparam logic signed [AW-1:0] UMax = AW'(((64'd1 << (W - 1)) - 64'd1) << FRAC);
    localparam logic signed [AW-1:0] UMin = -(AW'(64'd1 << (W - 1 + FRAC)));
    localparam logic signed [AW-1:0] Half = AW'(64'd1 << (FRAC - 1));
    localparam logic signed [AW-1:0] YMax = AW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic signed [AW-1:0] YMin = -(AW'(64'd1 << (W - 1)));

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 clr, expire, start, done;
    logic [ADC_BITS-1:0]  adc_data;
    logic signed [W-1:0]  pot_q, yk_q, kp_q, kd_q, y1_q, y2_q, y1_eff, y2_eff;
    logic                 yk_valid_q, first_q;
    logic signed [AW-1:0] u_q, acc_q, prod_ext, u_clamp, u_round, y_full;
    logic signed [W:0]    err, dy, d2, mul_b;
    logic signed [W-1:0]  mul_a, y_sat;
    logic signed [PW-1:0] prod;

    assign clr      = Rest || !Run;
    assign expire   = (cnt_q == CW'(SAMPLE_DIV - 1));
    assign start    = (state_q == StIdle) && expire;
    assign Pot      = pot_q;
    assign Yk       = yk_q;
    assign Yk_valid = yk_valid_q;

    servo_adc_serial #(
        .AdcBits (ADC_BITS),
        .SclkDiv (SCLK_DIV)
    ) u_serial (
        .clk_i   (Clk),
        .clr_i   (clr),
        .start_i (start),
        .sdata_i (sdata),
        .cs_o    (cs),
        .sclk_o  (sclk),
        .done_o  (done),
        .data_o  (adc_data)
    );

    // Free-running sample period; restarts whenever the loop is held off.
    always_ff @(posedge Clk) begin
        if (clr || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        y1_eff = first_q ? pot_q : y1_q;
        y2_eff = first_q ? pot_q : y2_q;
        err    = {Ref[W-1], Ref} - {pot_q[W-1], pot_q};
        dy     = {pot_q[W-1], pot_q} - {y1_eff[W-1], y1_eff};
        // Modular at W+1 bits; exact because samples are only ADC_BITS < W wide.
        d2     = {pot_q[W-1], pot_q} - {y1_eff, 1'b0} + {y2_eff[W-1], y2_eff};
        mul_a  = '0;
        mul_b  = '0;
        case (state_q)
            StCalcI: begin mul_a = Ki;   mul_b = err; end
            StCalcP: begin mul_a = kp_q; mul_b = dy;  end
            StCalcD: begin mul_a = kd_q; mul_b = d2;  end
            default: ;
        endcase
        prod     = mul_a * mul_b;
        prod_ext = {{(AW - PW){prod[PW-1]}}, prod};
        u_clamp  = (acc_q > UMax) ? UMax : ((acc_q < UMin) ? UMin : acc_q);
        u_round  = u_clamp + Half;
        y_full   = u_round >>> FRAC;
        y_sat    = y_full[W-1:0];
        if (y_full > YMax) begin
            y_sat = YMax[W-1:0];
        end else if (y_full < YMin) begin
            y_sat = YMin[W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (clr) begin
            state_q    <= StIdle;
            u_q        <= '0;
            acc_q      <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            kp_q       <= '0;
            kd_q       <= '0;
            yk_q       <= '0;
            yk_valid_q <= 1'b0;
            first_q    <= 1'b1;
            if (Rest) begin
                pot_q <= '0;
            end
        end else begin
            yk_valid_q <= 1'b0;
            case (state_q)
                StIdle: if (start) state_q <= StConv;
                StConv: begin
                    if (done) begin
                        pot_q   <= {{(W - ADC_BITS){1'b0}}, adc_data};
                        state_q <= StCalcI;
                    end
                end
                StCalcI: begin
                    acc_q   <= u_q + prod_ext;
                    kp_q    <= Kp;
                    kd_q    <= Kd;
                    state_q <= StCalcP;
                end
                StCalcP: begin
                    acc_q   <= acc_q - prod_ext;
                    state_q <= StCalcD;
                end
                StCalcD: begin
                    acc_q   <= acc_q - prod_ext;
                    state_q <= StUpdate;
                end
                StUpdate: begin
                    u_q        <= u_clamp;
                    yk_q       <= y_sat;
                    yk_valid_q <= 1'b1;
                    y2_q       <= y1_eff;
                    y1_q       <= pot_q;
                    first_q    <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
